// File: rtl/x_ramb_dp_ar_if.sv
// Port bundle for the dual-port, dual-aspect-ratio block RAM.
// Carries both ports' access signals and the registered collision flag.
interface x_ramb_dp_ar_if #(
  parameter int MEM_BITS = 4096,
  parameter int WIDTH_A  = 1,
  parameter int WIDTH_B  = 4
);
  localparam int AW_A = $clog2(MEM_BITS / WIDTH_A);
  localparam int AW_B = $clog2(MEM_BITS / WIDTH_B);

  logic               ena;
  logic               wea;
  logic               rsta;
  logic               regcea;
  logic [AW_A-1:0]    addra;
  logic [WIDTH_A-1:0] dia;
  logic [WIDTH_A-1:0] doa;

  logic               enb;
  logic               web;
  logic               rstb;
  logic               regceb;
  logic [AW_B-1:0]    addrb;
  logic [WIDTH_B-1:0] dib;
  logic [WIDTH_B-1:0] dob;

  logic               coll;

  modport master (
    output ena, wea, rsta, regcea, addra, dia,
    output enb, web, rstb, regceb, addrb, dib,
    input  doa, dob, coll
  );

  modport slave (
    input  ena, wea, rsta, regcea, addra, dia,
    input  enb, web, rstb, regceb, addrb, dib,
    output doa, dob, coll
  );
endinterface

// File: rtl/x_ramb_dp_ar.sv
// True dual-port RAM over one bit-addressed array, independent aspect ratio per port.
// Per-port write mode, optional output register, set/reset value and write-write collision flag.
module x_ramb_dp_ar #(
  parameter int               MEM_BITS     = 4096,
  parameter int               WIDTH_A      = 1,
  parameter int               WIDTH_B      = 4,
  parameter int               WRITE_MODE_A = 0,
  parameter int               WRITE_MODE_B = 0,
  parameter bit               DO_REG_A     = 1'b0,
  parameter bit               DO_REG_B     = 1'b0,
  parameter logic [WIDTH_A-1:0] SRVAL_A    = '0,
  parameter logic [WIDTH_B-1:0] SRVAL_B    = '0,
  parameter bit               INIT_VAL     = 1'b0
) (
  input logic           clk,
  input logic           rst_n,
  x_ramb_dp_ar_if.slave io
);
  localparam int WM_WRITE_FIRST = 0;
  localparam int WM_READ_FIRST  = 1;

  localparam int BW   = $clog2(MEM_BITS);
  localparam int LW_A = $clog2(WIDTH_A);
  localparam int LW_B = $clog2(WIDTH_B);

  logic [MEM_BITS-1:0] mem = {MEM_BITS{INIT_VAL}};

  logic [BW-1:0]      bit_a, bit_b;
  logic [BW:0]        end_a, end_b;
  logic [WIDTH_A-1:0] rd_a;
  logic [WIDTH_B-1:0] rd_b;
  logic [WIDTH_A-1:0] s1_a;
  logic [WIDTH_B-1:0] s1_b;
  logic               wr_a, wr_b;
  logic               coll_d, coll_q;

  // Word address -> lowest bit index; widths are powers of two, so a shift suffices.
  assign bit_a = BW'(io.addra) << LW_A;
  assign bit_b = BW'(io.addrb) << LW_B;
  assign end_a = {1'b0, bit_a} + (BW+1)'(WIDTH_A);
  assign end_b = {1'b0, bit_b} + (BW+1)'(WIDTH_B);

  assign wr_a = io.ena & io.wea;
  assign wr_b = io.enb & io.web;

  // Reads see the array before this edge's writes land, giving read-first
  // behaviour both on the same port and across ports.
  assign rd_a = mem[bit_a +: WIDTH_A];
  assign rd_b = mem[bit_b +: WIDTH_B];

  // NOTE: the storage array has no reset; contents survive rst_n and only the
  // time-zero value applies. Port A is written last so it wins overlapping bits.
  always_ff @(posedge clk) begin
    if (wr_b) mem[bit_b +: WIDTH_B] <= io.dib;
    if (wr_a) mem[bit_a +: WIDTH_A] <= io.dia;
  end

  // NOTE: every state register uses non-blocking assignment so all flops
  // sample the same pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_a <= SRVAL_A;
    end else if (io.ena) begin
      if (io.rsta)                         s1_a <= SRVAL_A;
      else if (!io.wea)                    s1_a <= rd_a;
      else if (WRITE_MODE_A == WM_WRITE_FIRST) s1_a <= io.dia;
      else if (WRITE_MODE_A == WM_READ_FIRST)  s1_a <= rd_a;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_b <= SRVAL_B;
    end else if (io.enb) begin
      if (io.rstb)                         s1_b <= SRVAL_B;
      else if (!io.web)                    s1_b <= rd_b;
      else if (WRITE_MODE_B == WM_WRITE_FIRST) s1_b <= io.dib;
      else if (WRITE_MODE_B == WM_READ_FIRST)  s1_b <= rd_b;
    end
  end

  generate
    if (DO_REG_A) begin : g_doreg_a
      logic [WIDTH_A-1:0] do_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          do_q <= SRVAL_A;
        else if (io.regcea)  do_q <= (io.ena && io.rsta) ? SRVAL_A : s1_a;
      end
      assign io.doa = do_q;
    end else begin : g_nodoreg_a
      logic unused_regce_a;
      assign unused_regce_a = io.regcea;
      assign io.doa = s1_a;
    end

    if (DO_REG_B) begin : g_doreg_b
      logic [WIDTH_B-1:0] do_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          do_q <= SRVAL_B;
        else if (io.regceb)  do_q <= (io.enb && io.rstb) ? SRVAL_B : s1_b;
      end
      assign io.dob = do_q;
    end else begin : g_nodoreg_b
      logic unused_regce_b;
      assign unused_regce_b = io.regceb;
      assign io.dob = s1_b;
    end
  endgenerate

  // NOTE: coll_d gets its default first so no path through the block can infer a latch.
  always_comb begin
    coll_d = 1'b0;
    if (wr_a && wr_b) coll_d = ({1'b0, bit_a} < end_b) && ({1'b0, bit_b} < end_a);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) coll_q <= 1'b0;
    else        coll_q <= coll_d;
  end

  assign io.coll = coll_q;
endmodule

// File: tb/tb_x_ramb_dp_ar.sv
// Bench for x_ramb_dp_ar: three configurations share one stimulus stream; directed
// vectors with hand-derived results, then random traffic against a bit-array model.
module tb_x_ramb_dp_ar;
  localparam int MEMB = 64;
  localparam int WA   = 1;
  localparam int WB   = 4;
  localparam int NDUT = 3;

  // Per-instance configuration: 0 = write-first/no regs, 1 = read-first/regs, 2 = no-change.
  localparam int WMA  [NDUT] = '{0, 1, 2};
  localparam int WMB  [NDUT] = '{0, 1, 2};
  localparam int DRA  [NDUT] = '{0, 1, 0};
  localparam int DRB  [NDUT] = '{0, 1, 0};
  localparam int SVA  [NDUT] = '{1, 0, 1};
  localparam int SVB  [NDUT] = '{'hA, 'h5, 'hA};
  localparam int INIT [NDUT] = '{0, 0, 1};

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena, wea, rsta, regcea, dia;
  logic [5:0] addra;
  logic       enb, web, rstb, regceb;
  logic [3:0] addrb, dib;

  logic       doa_w  [NDUT];
  logic [3:0] dob_w  [NDUT];
  logic       coll_w [NDUT];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    x_ramb_dp_ar_if #(.MEM_BITS(MEMB), .WIDTH_A(WA), .WIDTH_B(WB)) bus ();
    assign bus.ena = ena;   assign bus.wea = wea;   assign bus.rsta = rsta;
    assign bus.regcea = regcea; assign bus.addra = addra; assign bus.dia = dia;
    assign bus.enb = enb;   assign bus.web = web;   assign bus.rstb = rstb;
    assign bus.regceb = regceb; assign bus.addrb = addrb; assign bus.dib = dib;
    x_ramb_dp_ar #(
      .MEM_BITS(MEMB), .WIDTH_A(WA), .WIDTH_B(WB),
      .WRITE_MODE_A(WMA[g]), .WRITE_MODE_B(WMB[g]),
      .DO_REG_A(1'(DRA[g])), .DO_REG_B(1'(DRB[g])),
      .SRVAL_A(1'(SVA[g])), .SRVAL_B(4'(SVB[g])), .INIT_VAL(1'(INIT[g]))
    ) u_dut (.clk(clk), .rst_n(rst_n), .io(bus));
    assign doa_w[g]  = bus.doa;
    assign dob_w[g]  = bus.dob;
    assign coll_w[g] = bus.coll;
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // ---------------- reference model: plain bit arrays and per-port words ----------------
  bit         mm    [NDUT][MEMB];
  logic [3:0] m_s1a [NDUT];
  logic [3:0] m_s1b [NDUT];
  logic [3:0] m_oa  [NDUT];
  logic [3:0] m_ob  [NDUT];
  bit         m_coll[NDUT];

  function automatic logic [3:0] rd_word(int k, int base, int w);
    logic [3:0] r = '0;
    for (int i = 0; i < w; i++) r[i] = mm[k][base + i];
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NDUT; k++) begin
      m_s1a[k] = 4'(SVA[k]); m_oa[k] = 4'(SVA[k]);
      m_s1b[k] = 4'(SVB[k]); m_ob[k] = 4'(SVB[k]);
      m_coll[k] = 1'b0;
    end
  endtask

  task automatic model_step();
    int ba = int'(addra) * WA;
    int bb = int'(addrb) * WB;
    for (int k = 0; k < NDUT; k++) begin
      logic [3:0] old_a = rd_word(k, ba, WA);
      logic [3:0] old_b = rd_word(k, bb, WB);
      if (DRA[k] != 0 && regcea) m_oa[k] = (ena && rsta) ? 4'(SVA[k]) : m_s1a[k];
      if (DRB[k] != 0 && regceb) m_ob[k] = (enb && rstb) ? 4'(SVB[k]) : m_s1b[k];
      if (ena) begin
        if (rsta)             m_s1a[k] = 4'(SVA[k]);
        else if (!wea)        m_s1a[k] = old_a;
        else if (WMA[k] == 0) m_s1a[k] = {3'b0, dia};
        else if (WMA[k] == 1) m_s1a[k] = old_a;
      end
      if (enb) begin
        if (rstb)             m_s1b[k] = 4'(SVB[k]);
        else if (!web)        m_s1b[k] = old_b;
        else if (WMB[k] == 0) m_s1b[k] = dib;
        else if (WMB[k] == 1) m_s1b[k] = old_b;
      end
      m_coll[k] = ena && wea && enb && web && (ba < bb + WB) && (bb < ba + WA);
      if (enb && web) for (int i = 0; i < WB; i++) mm[k][bb + i] = dib[i];
      if (ena && wea) for (int i = 0; i < WA; i++) mm[k][ba + i] = dia;
    end
  endtask

  task automatic compare_model(input int cyc);
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("rnd%0d u%0d doa", cyc, k), 16'(doa_w[k]),
            16'((DRA[k] != 0) ? m_oa[k][0] : m_s1a[k][0]));
      check($sformatf("rnd%0d u%0d dob", cyc, k), 16'(dob_w[k]),
            16'((DRB[k] != 0) ? m_ob[k] : m_s1b[k]));
      check($sformatf("rnd%0d u%0d coll", cyc, k), 16'(coll_w[k]), 16'(m_coll[k]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
  endtask

  task automatic cycle();
    tick();
    @(negedge clk);
  endtask

  task automatic idle();
    ena = 0; wea = 0; rsta = 0; regcea = 1; addra = '0; dia = 0;
    enb = 0; web = 0; rstb = 0; regceb = 1; addrb = '0; dib = '0;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic       ena, wea, rsta;
    logic [5:0] addra;
    logic       dia;
    logic       enb, web, rstb, regceb;
    logic [3:0] addrb, dib;
    logic       e_doa0;
    logic [3:0] e_dob0, e_dob1, e_dob2;
    logic       e_coll0;
  } vec_t;

  function automatic vec_t mk(int a_en, int a_we, int a_rst, int a_ad, int a_di,
                              int b_en, int b_we, int b_rst, int b_ce, int b_ad, int b_di,
                              int x_a0, int x_b0, int x_b1, int x_b2, int x_c0);
    vec_t v;
    v.ena = 1'(a_en); v.wea = 1'(a_we); v.rsta = 1'(a_rst); v.addra = 6'(a_ad); v.dia = 1'(a_di);
    v.enb = 1'(b_en); v.web = 1'(b_we); v.rstb = 1'(b_rst); v.regceb = 1'(b_ce);
    v.addrb = 4'(b_ad); v.dib = 4'(b_di);
    v.e_doa0 = 1'(x_a0); v.e_dob0 = 4'(x_b0); v.e_dob1 = 4'(x_b1); v.e_dob2 = 4'(x_b2);
    v.e_coll0 = 1'(x_c0);
    return v;
  endfunction

  vec_t vt[$];

  initial begin
    // A: en we rst addr di | B: en we rst ce addr di | exp: doa0 dob0 dob1 dob2 coll0
    vt.push_back(mk(0,0,0, 0,0, 1,1,0,1,3,'hB, 1,'hB,'h5,'hA,0)); // aspect ratio write
    vt.push_back(mk(1,0,0,12,0, 0,0,0,1,0,0,   1,'hB,'h0,'hA,0));
    vt.push_back(mk(1,0,0,13,0, 0,0,0,1,0,0,   1,'hB,'h0,'hA,0));
    vt.push_back(mk(1,0,0,14,0, 0,0,0,1,0,0,   0,'hB,'h0,'hA,0));
    vt.push_back(mk(1,0,0,15,0, 0,0,0,1,0,0,   1,'hB,'h0,'hA,0));
    vt.push_back(mk(0,0,0, 0,0, 1,1,0,1,5,'h3, 1,'h3,'h0,'hA,0)); // write modes
    vt.push_back(mk(0,0,0, 0,0, 1,0,0,1,5,0,   1,'h3,'h0,'h3,0));
    vt.push_back(mk(0,0,0, 0,0, 1,1,0,1,5,'hC, 1,'hC,'h3,'h3,0));
    vt.push_back(mk(0,0,0, 0,0, 0,0,0,1,5,0,   1,'hC,'h3,'h3,0));
    vt.push_back(mk(0,0,0, 0,0, 1,0,0,1,5,0,   1,'hC,'h3,'hC,0));
    vt.push_back(mk(0,0,0, 0,0, 0,0,0,1,5,0,   1,'hC,'hC,'hC,0));
    vt.push_back(mk(0,0,0, 0,0, 1,1,0,1,2,'h9, 1,'h9,'hC,'hC,0)); // pipeline
    vt.push_back(mk(0,0,0, 0,0, 1,0,0,1,2,0,   1,'h9,'h0,'h9,0));
    vt.push_back(mk(0,0,0, 0,0, 0,0,0,1,2,0,   1,'h9,'h9,'h9,0));
    vt.push_back(mk(0,0,0, 0,0, 1,0,0,1,3,0,   1,'hB,'h9,'hB,0));
    vt.push_back(mk(0,0,0, 0,0, 0,0,0,0,3,0,   1,'hB,'h9,'hB,0));
    vt.push_back(mk(0,0,0, 0,0, 0,0,0,0,3,0,   1,'hB,'h9,'hB,0));
    vt.push_back(mk(0,0,0, 0,0, 0,0,0,1,3,0,   1,'hB,'hB,'hB,0));
    vt.push_back(mk(1,1,0, 8,1, 1,1,0,1,2,'h0, 1,'h0,'hB,'hB,1)); // collision
    vt.push_back(mk(0,0,0, 0,0, 1,0,0,1,2,0,   1,'h1,'h9,'h1,0));
    vt.push_back(mk(0,0,0, 0,0, 0,0,0,1,2,0,   1,'h1,'h1,'h1,0));
    vt.push_back(mk(1,0,0, 9,0, 1,1,0,1,2,'hF, 0,'hF,'h1,'h1,0)); // cross-port read/write
    vt.push_back(mk(1,0,0, 9,0, 0,0,0,1,2,0,   1,'hF,'h1,'h1,0));
    vt.push_back(mk(0,0,0, 0,0, 1,1,1,1,4,'h6, 1,'hA,'h5,'hA,0)); // sync set/reset + write
    vt.push_back(mk(0,0,0, 0,0, 1,0,0,1,4,0,   1,'h6,'h5,'h6,0));
    vt.push_back(mk(0,0,0, 0,0, 0,0,0,1,4,0,   1,'h6,'h6,'h6,0));

    for (int k = 0; k < NDUT; k++)
      for (int i = 0; i < MEMB; i++) mm[k][i] = 1'(INIT[k]);

    // Reset held across clock edges.
    rst_n = 1'b0;
    idle();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("rst doa0", 16'(doa_w[0]), 16'h1);
    check("rst dob0", 16'(dob_w[0]), 16'hA);
    check("rst coll0", 16'(coll_w[0]), 16'h0);
    check("rst doa1", 16'(doa_w[1]), 16'h0);
    check("rst dob1", 16'(dob_w[1]), 16'h5);
    check("rst dob2", 16'(dob_w[2]), 16'hA);
    rst_n = 1'b1;
    cycle();
    check("rel doa0", 16'(doa_w[0]), 16'h1);
    check("rel dob0", 16'(dob_w[0]), 16'hA);
    check("rel dob1", 16'(dob_w[1]), 16'h5);

    for (int i = 0; i < vt.size(); i++) begin
      ena = vt[i].ena; wea = vt[i].wea; rsta = vt[i].rsta; addra = vt[i].addra; dia = vt[i].dia;
      enb = vt[i].enb; web = vt[i].web; rstb = vt[i].rstb; regceb = vt[i].regceb;
      addrb = vt[i].addrb; dib = vt[i].dib; regcea = 1'b1;
      cycle();
      check($sformatf("vec%0d doa0", i), 16'(doa_w[0]), 16'(vt[i].e_doa0));
      check($sformatf("vec%0d dob0", i), 16'(dob_w[0]), 16'(vt[i].e_dob0));
      check($sformatf("vec%0d dob1", i), 16'(dob_w[1]), 16'(vt[i].e_dob1));
      check($sformatf("vec%0d dob2", i), 16'(dob_w[2]), 16'(vt[i].e_dob2));
      check($sformatf("vec%0d coll0", i), 16'(coll_w[0]), 16'(vt[i].e_coll0));
    end

    // Async reset between edges during a pipelined read; memory must survive.
    idle(); enb = 1; web = 1; addrb = 4'd6; dib = 4'h7;
    cycle();
    check("mid wr dob0", 16'(dob_w[0]), 16'h7);
    idle(); enb = 1; addrb = 4'd6;
    tick();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("mid rst dob1", 16'(dob_w[1]), 16'h5);
    check("mid rst dob0", 16'(dob_w[0]), 16'hA);
    check("mid rst doa0", 16'(doa_w[0]), 16'h1);
    check("mid rst dob2", 16'(dob_w[2]), 16'hA);
    check("mid rst coll0", 16'(coll_w[0]), 16'h0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    idle(); enb = 1; addrb = 4'd6;
    cycle();
    check("post rst dob0", 16'(dob_w[0]), 16'h7);
    check("post rst dob2", 16'(dob_w[2]), 16'h7);
    check("post rst dob1 srval", 16'(dob_w[1]), 16'h5);
    idle();
    cycle();
    check("post rst dob1", 16'(dob_w[1]), 16'h7);

    // Random traffic against the model; addresses biased toward overlapping words.
    for (int c = 0; c < 400; c++) begin
      ena    = ($urandom_range(0, 3) != 0);
      wea    = 1'($urandom_range(0, 1));
      rsta   = ($urandom_range(0, 7) == 0);
      regcea = ($urandom_range(0, 3) != 0);
      dia    = 1'($urandom_range(0, 1));
      enb    = ($urandom_range(0, 3) != 0);
      web    = 1'($urandom_range(0, 1));
      rstb   = ($urandom_range(0, 7) == 0);
      regceb = ($urandom_range(0, 3) != 0);
      addrb  = 4'($urandom_range(0, 15));
      dib    = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) != 0) addra = {addrb, 2'($urandom_range(0, 3))};
      else                           addra = 6'($urandom_range(0, 63));
      cycle();
      compare_model(c);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
